// File: rtl/mem_layout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_layout_pkg
// Description : Shared widths and state encoding for the PWL waveform DMA
//               receive path.
//               DMA_DATA_WIDTH : useful bits carried per stream beat.
//               pwl_rx_state_e : receiver state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_layout_pkg;

  localparam int DMA_DATA_WIDTH = 48;

  typedef enum logic [1:0] {
    PWL_RX_IDLE = 2'd0,
    PWL_RX_RECV = 2'd1,
    PWL_RX_DONE = 2'd2,
    PWL_RX_ERR  = 2'd3
  } pwl_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/pwl_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : pwl_buffer_ram
// Description : Simple dual-port frame buffer, DEPTH x DATA_WIDTH.
//               The write is synchronous and the read is registered with
//               1-cycle latency, so the array maps onto block RAM.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address, sampled on the rising edge
//   rdata_o : read data, valid one cycle after raddr_i
// Revision    : 1.0 - initial release
// ============================================================================
module pwl_buffer_ram #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 48
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // No reset on the array or the read register; that lets it infer BRAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/pwl_dma_receiver.sv
`default_nettype none
// ============================================================================
// Module      : pwl_dma_receiver
// Description : Stream-side responder for PWL waveform DMA transfers.
//               It accepts one AXI-Stream frame per arm, stores the low
//               DATA_WIDTH bits of each beat, and reports the frame length on
//               tlast. It then holds the frame for read-back by address
//               until clr.
//   Optional feature macro: PWL_TKEEP_CHECK_EN. When it is defined, an
//   accepted beat whose tkeep is not all ones sets err_keep.
//   dac_clk, dac_rst       : clock and synchronous active-high reset
//   arm, clr               : open for one frame / release frame and errors
//   pwl_t*                 : AXI-Stream slave (tready registered)
//   frame_valid, frame_len : held-frame status
//   rd_addr, rd_data       : buffer read-back, 1-cycle latency
//   err_overflow, err_keep : sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module pwl_dma_receiver
  import mem_layout_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = DMA_DATA_WIDTH
) (
  input  logic                       dac_clk,
  input  logic                       dac_rst,
  input  logic                       arm,
  input  logic                       clr,
  input  logic [63:0]                pwl_tdata,
  input  logic [7:0]                 pwl_tkeep,
  input  logic                       pwl_tlast,
  input  logic                       pwl_tvalid,
  output logic                       pwl_tready,
  output logic                       frame_valid,
  output logic [$clog2(DEPTH+1)-1:0] frame_len,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       err_overflow,
  output logic                       err_keep
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [LW-1:0] C_FULL = LW'(DEPTH);

  pwl_rx_state_e         state_q;
  logic [LW-1:0]         wr_idx_q;
  logic                  tready_q;
  logic                  frame_valid_q;
  logic [LW-1:0]         frame_len_q;
  logic                  err_overflow_q;
  logic                  err_keep_q;
  logic                  rd_ok_q;

  logic                  beat_acc_w;
  logic                  keep_bad_w;
  logic                  ram_we_w;
  logic [DATA_WIDTH-1:0] ram_rdata_w;
  logic                  unused_ok;

  assign beat_acc_w = pwl_tvalid && tready_q;

`ifdef PWL_TKEEP_CHECK_EN
  assign keep_bad_w = beat_acc_w && (pwl_tkeep != 8'hFF);
`else
  assign keep_bad_w = 1'b0;
`endif

  // Bits above DATA_WIDTH are ignored, and tkeep is only used by the
  // optional check.
  assign unused_ok = ^{pwl_tdata[63:DATA_WIDTH], pwl_tkeep};

  // A beat reaches the buffer only in RECV with room left. clr and reset
  // take priority, so a beat on those edges is dropped.
  assign ram_we_w = beat_acc_w && (state_q == PWL_RX_RECV) &&
                    (wr_idx_q != C_FULL) && !clr && !dac_rst;

  always_ff @(posedge dac_clk) begin
    if (dac_rst || clr) begin
      state_q        <= PWL_RX_IDLE;
      wr_idx_q       <= '0;
      tready_q       <= 1'b0;
      frame_valid_q  <= 1'b0;
      frame_len_q    <= '0;
      err_overflow_q <= 1'b0;
      err_keep_q     <= 1'b0;
    end else begin
      if (keep_bad_w) begin
        err_keep_q <= 1'b1;
      end
      case (state_q)
        PWL_RX_IDLE: begin
          if (arm) begin
            state_q  <= PWL_RX_RECV;
            wr_idx_q <= '0;
            tready_q <= 1'b1;
          end
        end
        PWL_RX_RECV: begin
          if (beat_acc_w) begin
            if (wr_idx_q == C_FULL) begin
              // Buffer already full: drop the beat. Drain the rest of the
              // frame, unless this beat is already the last one.
              err_overflow_q <= 1'b1;
              if (pwl_tlast) begin
                state_q  <= PWL_RX_IDLE;
                tready_q <= 1'b0;
              end else begin
                state_q  <= PWL_RX_ERR;
              end
            end else begin
              wr_idx_q <= wr_idx_q + 1'b1;
              if (pwl_tlast) begin
                state_q       <= PWL_RX_DONE;
                tready_q      <= 1'b0;
                frame_valid_q <= 1'b1;
                frame_len_q   <= wr_idx_q + 1'b1;
              end
            end
          end
        end
        PWL_RX_DONE: begin
          // Hold the frame until clr.
        end
        PWL_RX_ERR: begin
          if (beat_acc_w && pwl_tlast) begin
            state_q  <= PWL_RX_IDLE;
            tready_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= PWL_RX_IDLE;
          tready_q <= 1'b0;
        end
      endcase
    end
  end

  // The in-range decision is registered in step with the RAM read, so
  // rd_data only ever shows entries from the held frame.
  always_ff @(posedge dac_clk) begin
    if (dac_rst) begin
      rd_ok_q <= 1'b0;
    end else begin
      rd_ok_q <= frame_valid_q && (LW'(rd_addr) < frame_len_q);
    end
  end

  pwl_buffer_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buffer (
    .clk_i   (dac_clk),
    .we_i    (ram_we_w),
    .waddr_i (wr_idx_q[AW-1:0]),
    .wdata_i (pwl_tdata[DATA_WIDTH-1:0]),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata_w)
  );

  assign pwl_tready   = tready_q;
  assign frame_valid  = frame_valid_q;
  assign frame_len    = frame_len_q;
  assign err_overflow = err_overflow_q;
  assign err_keep     = err_keep_q;
  assign rd_data      = (rd_ok_q && frame_valid_q) ? ram_rdata_w : '0;

endmodule
`default_nettype wire

// File: tb/tb_pwl_dma_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwl_dma_receiver
// Description : Self-checking bench for pwl_dma_receiver (DEPTH = 8).
//               The reference model is a per-frame outcome rule. A frame of
//               n beats is held with length n when n <= DEPTH. Otherwise it
//               sets the sticky overflow flag and leaves no frame held.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwl_dma_receiver;

  localparam int DEPTH = 8;
  localparam int DW    = 48;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          arm = 1'b0;
  logic          clr = 1'b0;
  logic [63:0]   tdata = '0;
  logic [7:0]    tkeep = 8'hFF;
  logic          tlast = 1'b0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          frame_valid;
  logic [LW-1:0] frame_len;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          err_overflow;
  logic          err_keep;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] tx_q[$];
  bit          exp_ovf  = 1'b0;
  bit          exp_keep = 1'b0;

  always #5 clk = ~clk;

  pwl_dma_receiver #(.DEPTH(DEPTH)) dut (
    .dac_clk      (clk),
    .dac_rst      (rst),
    .arm          (arm),
    .clr          (clr),
    .pwl_tdata    (tdata),
    .pwl_tkeep    (tkeep),
    .pwl_tlast    (tlast),
    .pwl_tvalid   (tvalid),
    .pwl_tready   (tready),
    .frame_valid  (frame_valid),
    .frame_len    (frame_len),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .err_overflow (err_overflow),
    .err_keep     (err_keep)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int n);
    tx_q.delete();
    for (int i = 0; i < n; i++) tx_q.push_back({$urandom, $urandom});
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_ovf  = 1'b0;
    exp_keep = 1'b0;
  endtask

  // Called at a negedge. Each beat is held until a rising edge sees
  // tvalid && tready; idle gaps are inserted at random when requested.
  task automatic send_beats(input int n, input bit with_last, input bit gaps, input int bad_idx);
    for (int i = 0; i < n; i++) begin
      bit done = 1'b0;
      int waited = 0;
      while (!done) begin
        if (gaps && $urandom_range(0, 2) == 0) begin
          tvalid = 1'b0;
          tdata  = {$urandom, $urandom};
        end else begin
          tvalid = 1'b1;
          tdata  = tx_q[i];
          tlast  = with_last && (i == n - 1);
          tkeep  = (i == bad_idx) ? 8'h0F : 8'hFF;
          done   = tready;
        end
        @(negedge clk);
        waited++;
        if (!done && waited > 20) begin
          chk("beat_timeout", {63'd0, tready}, 64'd1);
          tvalid = 1'b0;
          tlast  = 1'b0;
          return;
        end
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = 8'hFF;
  endtask

  task automatic check_frame(input int n, input string tag);
    bit held;
    held = (n <= DEPTH);
    chk({tag, "_tready"}, {63'd0, tready}, 64'd0);
    chk({tag, "_valid"}, {63'd0, frame_valid}, {63'd0, held});
    chk({tag, "_len"}, 64'(frame_len), held ? 64'(n) : 64'd0);
    chk({tag, "_ovf"}, {63'd0, err_overflow}, {63'd0, exp_ovf});
    chk({tag, "_keep"}, {63'd0, err_keep}, {63'd0, exp_keep});
    for (int a = 0; a < DEPTH; a++) begin
      logic [63:0] e;
      rd_addr = AW'(a);
      @(negedge clk);
      e = (held && a < n) ? {16'd0, tx_q[a][DW-1:0]} : 64'd0;
      chk($sformatf("%s_rd%0d", tag, a), {16'd0, rd_data}, e);
    end
  endtask

  // Arms, sends tx_q as one frame, updates the model and checks the result.
  task automatic run_frame(input int n, input bit gaps, input int bad_idx, input string tag);
    pulse_arm();
    chk({tag, "_armed"}, {63'd0, tready}, 64'd1);
    send_beats(n, 1'b1, gaps, bad_idx);
    if (n > DEPTH) exp_ovf = 1'b1;
`ifdef PWL_TKEEP_CHECK_EN
    if (bad_idx >= 0 && bad_idx < n) exp_keep = 1'b1;
`endif
    check_frame(n, tag);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_tready", {63'd0, tready}, 64'd0);
    chk("rst_valid", {63'd0, frame_valid}, 64'd0);
    chk("rst_len", 64'(frame_len), 64'd0);
    chk("rst_rd", {16'd0, rd_data}, 64'd0);
    chk("rst_ovf", {63'd0, err_overflow}, 64'd0);
    chk("rst_keep", {63'd0, err_keep}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tready", {63'd0, tready}, 64'd0);

    // Directed 7-beat frame; junk placed above bit 47 must be ignored.
    tx_q.delete();
    tx_q.push_back({16'hDEAD, 48'd65729});
    tx_q.push_back({16'hBEEF, 48'd412316925960});
    tx_q.push_back({16'h1234, 48'd433791631384});
    tx_q.push_back({16'hFFFF, 48'd382252023969});
    tx_q.push_back({16'h0001, 48'd38654640144});
    tx_q.push_back({16'h8000, 48'd16});
    tx_q.push_back({16'h5A5A, 48'd609});
    run_frame(7, 1'b0, -1, "dir7");

    // arm while a frame is held is ignored.
    pulse_arm();
    chk("done_arm_tready", {63'd0, tready}, 64'd0);
    chk("done_arm_valid", {63'd0, frame_valid}, 64'd1);

    // clr while a frame is held.
    pulse_clr();
    chk("clr_valid", {63'd0, frame_valid}, 64'd0);
    chk("clr_len", 64'(frame_len), 64'd0);
    chk("clr_tready", {63'd0, tready}, 64'd0);
    @(negedge clk);
    chk("clr_rd", {16'd0, rd_data}, 64'd0);

    fill_random(3);
    run_frame(3, 1'b0, -1, "after_clr3");

    // arm and clr in the same cycle: clr wins.
    pulse_clr();
    arm = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    clr = 1'b0;
    chk("armclr_tready", {63'd0, tready}, 64'd0);

    fill_random(DEPTH);
    run_frame(DEPTH, 1'b0, -1, "full");

    pulse_clr();
    fill_random(DEPTH + 2);
    run_frame(DEPTH + 2, 1'b0, -1, "ovf10");

    // Overflow sticks across arm; the next frame still completes.
    fill_random(3);
    run_frame(3, 1'b0, -1, "sticky");

    pulse_clr();
    fill_random(DEPTH + 1);
    run_frame(DEPTH + 1, 1'b0, -1, "ovf_last");

    for (int f = 0; f < 8; f++) begin
      pulse_clr();
      n = $urandom_range(1, DEPTH + 3);
      fill_random(n);
      run_frame(n, 1'b1, -1, $sformatf("rnd%0d", f));
    end

    // Reset in the middle of a 7-beat frame, while beat 4 is on the bus.
    pulse_clr();
    fill_random(7);
    pulse_arm();
    send_beats(3, 1'b0, 1'b0, -1);
    tvalid = 1'b1;
    tdata  = tx_q[3];
    rst    = 1'b1;
    @(negedge clk);
    tvalid = 1'b0;
    chk("mid_rst_tready", {63'd0, tready}, 64'd0);
    chk("mid_rst_valid", {63'd0, frame_valid}, 64'd0);
    chk("mid_rst_len", 64'(frame_len), 64'd0);
    chk("mid_rst_rd", {16'd0, rd_data}, 64'd0);
    chk("mid_rst_ovf", {63'd0, err_overflow}, 64'd0);
    chk("mid_rst_keep", {63'd0, err_keep}, 64'd0);
    rst = 1'b0;
    exp_ovf  = 1'b0;
    exp_keep = 1'b0;
    @(negedge clk);
    fill_random(7);
    run_frame(7, 1'b1, -1, "post_rst");

    // Partial tkeep on beat 2 of a 5-beat frame.
    pulse_clr();
    fill_random(5);
    run_frame(5, 1'b0, 2, "keep");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
